finger_track_scheduler: RTL and testbench
=========================================

FINGER_TRACK_SCHEDULER -- requirements
Module: finger_track_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 3, number of finger colour profiles time-multiplexed onto one tracker (legal 1..4).
REQ-002 Parameter LOST_FRAMES, default 4, consecutive missed visits before a slot is flagged lost (legal 1..15).
REQ-003 clk  in  1  single system/pixel clock; all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sched_en  in  1  high = run slot rotation; low = finish current frame, then park in IDLE.
REQ-006 vsync  in  1  camera vsync; falling edge marks frame done.
REQ-007 cfg_we / cfg_addr / cfg_wdata  in  1 / 2 / 15  profile write port; wdata = {min_bright[14:10], margin[9:5], max_other[4:0]}.
REQ-008 trk_min_bright / trk_margin / trk_max_other  out  5 / 5 / 5  thresholds driven to the shared tracker.
REQ-009 trk_hit  in  1  tracker reports box larger than 10x10 for the frame just ended.
REQ-010 trk_center_x / trk_center_y  in  10 / 10  tracker centre outputs.
REQ-011 active_slot  out  2  slot currently configured on the tracker.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake; transfer when both high on a clock edge.
REQ-013 res_slot / res_hit / res_x / res_y  out  2 / 1 / 10 / 10  result payload.
REQ-014 lost  out  NUM_SLOTS  per-slot lost flags.
REQ-015 frame_skip  out  1  one-cycle pulse when a frame ends while a result is stalled.

Function
REQ-016 frame_done SHALL be vsync_d & ~vsync, vsync_d registered on clk.
REQ-017 FSM states SHALL be IDLE, ARM, TRACK, COLLECT, PUBLISH.
REQ-018 IDLE -> ARM on frame_done when sched_en=1; otherwise stay.
REQ-019 ARM SHALL last one cycle, copy profile[active_slot] into trk_* registers, go TRACK.
REQ-020 TRACK -> COLLECT on frame_done; trk_* SHALL be stable for the whole TRACK frame.
REQ-021 COLLECT SHALL last one cycle, sample trk_hit/trk_center_x/trk_center_y into res_* (tracker updates centre on the frame_done edge), go PUBLISH.
REQ-022 PUBLISH SHALL hold res_valid=1 and payload stable until res_ready; on transfer, active_slot advances (NUM_SLOTS-1 wraps to 0), go ARM if sched_en=1 else IDLE.
REQ-023 frame_done during PUBLISH with res_ready=0 SHALL pulse frame_skip, leave payload unchanged; the following ARM waits for nothing (first full frame after ARM is the tracked one, partial frames are discarded by TRACK ending only at next frame_done after ARM).
REQ-024 frame_done and res_ready in the same PUBLISH cycle: transfer wins, no frame_skip.
REQ-025 cfg_we writes profile[cfg_addr] next edge; cfg_addr >= NUM_SLOTS ignored; write to the active slot during TRACK takes effect at its next ARM.
REQ-026 Per slot a 4-bit miss counter: COLLECT with res_hit=0 increments (saturating 15), res_hit=1 clears; lost[s] = counter >= LOST_FRAMES.
REQ-027 Latency frame_done -> res_valid SHALL be exactly 2 clocks.

Reset
REQ-028 Reset SHALL force IDLE, active_slot=0, res_valid=0, res_*=0, frame_skip=0, lost=0, miss counters=0, vsync_d=0.
REQ-029 Reset SHALL load every profile and trk_* to {7,6,6}; reset mid-frame abandons the frame with no result.

Configuration
REQ-030 Macro FTS_LOST_DETECT_EN: defined -> REQ-026 implemented; undefined -> counters absent, lost tied to 0.

Structure
REQ-031 Package finger_track_pkg SHALL hold the FSM state enum, the profile struct typedef (three 5-bit fields) and the reset-default profile constant.
REQ-032 Sub-module vsync_fall_det (one register, one output pulse) SHALL generate frame_done.

Verification
REQ-033 Reset, sched_en=1, 3 frames, res_ready=1 -> results for slots 0,1,2 in order, each res_valid 2 clocks after frame_done.
REQ-034 cfg write slot1 = {9,4,3} during slot0 TRACK -> trk_* = {9,4,3} only from slot1 ARM onward.
REQ-035 res_ready held 0 across 2 frame_done -> 2 frame_skip pulses, payload unchanged, then transfer on ready.
REQ-036 Slot2 trk_hit=0 for 4 visits (LOST_FRAMES=4) -> lost[2]=1 after 4th COLLECT; one hit -> lost[2]=0.
REQ-037 reset asserted in TRACK -> all outputs at reset values within the same cycle, no res_valid until a new full frame.
REQ-038 sched_en dropped in TRACK -> current result delivered, then IDLE, active_slot advanced by one.

Source files
------------

// File: rtl/finger_track_pkg.sv
// Shared types for the finger tracking scheduler: FSM states, colour profile
// layout and the profile loaded at reset.
package finger_track_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_TRACK   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_PUBLISH = 3'd4
  } fts_state_t;

  typedef struct packed {
    logic [4:0] min_bright;
    logic [4:0] margin;
    logic [4:0] max_other;
  } profile_t;

  localparam profile_t PROFILE_RESET = '{min_bright: 5'd7, margin: 5'd6, max_other: 5'd6};

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    if (v == 4'd15) sat_inc4 = 4'd15;
    else            sat_inc4 = v + 4'd1;
  endfunction

endpackage

// File: rtl/vsync_fall_det.sv
// Falling-edge detector on camera vsync; the one-cycle pulse marks frame done.
module vsync_fall_det (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_done
);

  logic vsync_d;

  // delayed copy of vsync for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= vsync;
  end

  assign frame_done = vsync_d & ~vsync;

endmodule

// File: rtl/finger_track_scheduler.sv
// Time-multiplexes NUM_SLOTS colour profiles onto one tracker, one frame each.
// Optional per-slot lost detection is built when FTS_LOST_DETECT_EN is defined.
module finger_track_scheduler
  import finger_track_pkg::*;
#(
  parameter int NUM_SLOTS   = 3,
  parameter int LOST_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sched_en,
  input  logic                 vsync,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [14:0]          cfg_wdata,
  output logic [4:0]           trk_min_bright,
  output logic [4:0]           trk_margin,
  output logic [4:0]           trk_max_other,
  input  logic                 trk_hit,
  input  logic [9:0]           trk_center_x,
  input  logic [9:0]           trk_center_y,
  output logic [1:0]           active_slot,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_slot,
  output logic                 res_hit,
  output logic [9:0]           res_x,
  output logic [9:0]           res_y,
  output logic [NUM_SLOTS-1:0] lost,
  output logic                 frame_skip
);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 4) begin : g_bad_slots
    $error("NUM_SLOTS must be 1..4");
  end
  if (LOST_FRAMES < 1 || LOST_FRAMES > 15) begin : g_bad_lost
    $error("LOST_FRAMES must be 1..15");
  end

  localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);
  localparam logic [2:0] SLOT_CNT  = 3'(NUM_SLOTS);

  fts_state_t state, next_state;
  logic       frame_done;
  logic       load_trk, load_res, xfer, skip;
  profile_t   profile [4];
  profile_t   trk_cfg;

  vsync_fall_det u_vsync_fall_det (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .frame_done (frame_done)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic; a frame end during IDLE arms, so the tracked frame is always a full one
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (frame_done && sched_en) next_state = ST_ARM;
                  else                        next_state = ST_IDLE;
      ST_ARM:     next_state = ST_TRACK;
      ST_TRACK:   if (frame_done) next_state = ST_COLLECT;
                  else            next_state = ST_TRACK;
      ST_COLLECT: next_state = ST_PUBLISH;
      ST_PUBLISH: if (res_ready) next_state = sched_en ? ST_ARM : ST_IDLE;
                  else           next_state = ST_PUBLISH;
      default:    next_state = ST_IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    load_trk = 1'b0;
    load_res = 1'b0;
    xfer     = 1'b0;
    skip     = 1'b0;
    case (state)
      ST_ARM:     load_trk = 1'b1;
      ST_COLLECT: load_res = 1'b1;
      ST_PUBLISH: begin
        xfer = res_ready;
        skip = frame_done & ~res_ready;
      end
      default:    load_trk = 1'b0;
    endcase
  end

  // profile table; out-of-range addresses are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 4; s++) profile[s] <= PROFILE_RESET;
    end else if (cfg_we && ({1'b0, cfg_addr} < SLOT_CNT)) begin
      profile[cfg_addr] <= profile_t'(cfg_wdata);
    end
  end

  // tracker thresholds, only reloaded in ARM so they stay frozen through TRACK
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         trk_cfg <= PROFILE_RESET;
    else if (load_trk) trk_cfg <= profile[active_slot];
  end

  assign trk_min_bright = trk_cfg.min_bright;
  assign trk_margin     = trk_cfg.margin;
  assign trk_max_other  = trk_cfg.max_other;

  // slot rotation on each accepted result
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     active_slot <= 2'd0;
    else if (xfer) active_slot <= (active_slot == LAST_SLOT) ? 2'd0 : active_slot + 2'd1;
  end

  // result payload, valid flag and skip pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_slot   <= 2'd0;
      res_hit    <= 1'b0;
      res_x      <= 10'd0;
      res_y      <= 10'd0;
      res_valid  <= 1'b0;
      frame_skip <= 1'b0;
    end else begin
      if (load_res) begin
        res_slot <= active_slot;
        res_hit  <= trk_hit;
        res_x    <= trk_center_x;
        res_y    <= trk_center_y;
      end
      res_valid  <= (next_state == ST_PUBLISH);
      frame_skip <= skip;
    end
  end

`ifdef FTS_LOST_DETECT_EN
  localparam logic [3:0] LOST_TH = 4'(LOST_FRAMES);
  logic [3:0] miss_cnt [NUM_SLOTS];
  logic [3:0] miss_nxt [NUM_SLOTS];

  // per-slot miss counter update for the slot being collected
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (load_res && (2'(s) == active_slot)) begin
        if (trk_hit) miss_nxt[s] = 4'd0;
        else         miss_nxt[s] = sat_inc4(miss_cnt[s]);
      end else begin
        miss_nxt[s] = miss_cnt[s];
      end
    end
  end

  // miss counters and registered lost flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) miss_cnt[s] <= 4'd0;
      lost <= {NUM_SLOTS{1'b0}};
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        miss_cnt[s] <= miss_nxt[s];
        lost[s]     <= (miss_nxt[s] >= LOST_TH);
      end
    end
  end
`else
  assign lost = {NUM_SLOTS{1'b0}};
`endif

endmodule

// File: tb/tb_finger_track_scheduler.sv
// Self-checking bench: directed scenario sequence with randomized frame timing,
// tracker data and profiles, checked against a per-visit behavioural model.
module tb_finger_track_scheduler;

  localparam int NS = 3;
  localparam int LF = 4;
  localparam logic [14:0] RST_PROF = 15'((7 << 10) | (6 << 5) | 6);

  logic        clk = 1'b0;
  logic        reset, sched_en, vsync, cfg_we, trk_hit, res_ready;
  logic [1:0]  cfg_addr;
  logic [14:0] cfg_wdata;
  logic [9:0]  trk_center_x, trk_center_y;
  logic [4:0]  trk_min_bright, trk_margin, trk_max_other;
  logic [1:0]  active_slot, res_slot;
  logic        res_valid, res_hit, frame_skip;
  logic [9:0]  res_x, res_y;
  logic [NS-1:0] lost;

  int tests = 0;
  int fails = 0;

  logic [14:0] m_prof [4];
  logic [14:0] m_trk;
  int          m_slot;
  int          m_miss [NS];

  finger_track_scheduler #(.NUM_SLOTS(NS), .LOST_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .vsync(vsync),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .trk_min_bright(trk_min_bright), .trk_margin(trk_margin), .trk_max_other(trk_max_other),
    .trk_hit(trk_hit), .trk_center_x(trk_center_x), .trk_center_y(trk_center_y),
    .active_slot(active_slot), .res_valid(res_valid), .res_ready(res_ready),
    .res_slot(res_slot), .res_hit(res_hit), .res_x(res_x), .res_y(res_y),
    .lost(lost), .frame_skip(frame_skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] exp_lost();
    logic [NS-1:0] l;
    for (int s = 0; s < NS; s++) begin
`ifdef FTS_LOST_DETECT_EN
      l[s] = (m_miss[s] >= LF);
`else
      l[s] = 1'b0;
`endif
    end
    return l;
  endfunction

  function automatic logic [14:0] trk_now();
    return {trk_min_bright, trk_margin, trk_max_other};
  endfunction

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_prof[s] = RST_PROF;
    for (int s = 0; s < NS; s++) m_miss[s] = 0;
    m_trk  = RST_PROF;
    m_slot = 0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [14:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    if (int'(addr) < NS) m_prof[addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic vsync_fall(input int high_cycles);
    @(negedge clk);
    vsync = 1'b1;
    repeat (high_cycles) @(negedge clk);
    vsync = 1'b0;
  endtask

  // one tracked frame from TRACK: result, optional stalls, then re-arm (or park)
  task automatic tracked_frame(input logic hit, input int stalls, input logic coincide);
    logic [9:0] x, y;
    x = 10'($urandom_range(0, 1023));
    y = 10'($urandom_range(0, 1023));
    @(negedge clk);
    vsync = 1'b1;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    vsync = 1'b0;
    trk_hit = hit; trk_center_x = x; trk_center_y = y;
    res_ready = (stalls == 0);
    settle();
    check("lat1_no_valid", res_valid, 1'b0);
    settle();
    if (hit) m_miss[m_slot] = 0;
    else if (m_miss[m_slot] < 15) m_miss[m_slot]++;
    check("lat2_valid", res_valid, 1'b1);
    check("res_slot", res_slot, m_slot);
    check("res_hit", res_hit, hit);
    check("res_x", res_x, x);
    check("res_y", res_y, y);
    check("lost", lost, exp_lost());
    for (int k = 0; k < stalls; k++) begin
      @(negedge clk);
      vsync = 1'b1;
      trk_hit = ~hit; trk_center_x = 10'($urandom_range(0, 1023));
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      settle();
      check("skip_pulse", frame_skip, 1'b1);
      check("stall_valid", res_valid, 1'b1);
      check("stall_x", res_x, x);
      check("stall_hit", res_hit, hit);
      settle();
      check("skip_end", frame_skip, 1'b0);
    end
    if (stalls > 0) begin
      if (coincide) begin
        vsync_fall(2);
        res_ready = 1'b1;
      end else begin
        @(negedge clk);
        res_ready = 1'b1;
      end
    end
    settle();
    m_slot = (m_slot + 1) % NS;
    check("xfer_valid_low", res_valid, 1'b0);
    check("xfer_no_skip", frame_skip, 1'b0);
    check("active_slot", active_slot, m_slot);
    settle();
    if (sched_en) m_trk = m_prof[m_slot];
    check("trk_cfg", trk_now(), m_trk);
  endtask

  initial begin
    reset = 1'b1; sched_en = 1'b1; vsync = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 15'd0; trk_hit = 1'b0; trk_center_x = 10'd0; trk_center_y = 10'd0;
    res_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_valid, 1'b0);
    check("rst_slot", active_slot, 2'd0);
    check("rst_trk", trk_now(), RST_PROF);
    check("rst_lost", lost, 3'd0);
    check("rst_skip", frame_skip, 1'b0);
    check("rst_res", {res_slot, res_hit, res_x, res_y}, 23'd0);
    @(negedge clk);
    reset = 1'b0;

    // first frame end arms slot 0
    vsync_fall(2);
    settle();
    check("arm_no_valid", res_valid, 1'b0);
    settle();
    check("track0_trk", trk_now(), m_trk);

    // profile writes during slot0 TRACK, including its own slot and an ignored address
    cfg_write(2'd1, 15'((9 << 10) | (4 << 5) | 3));
    cfg_write(2'd0, 15'($urandom_range(0, 32767)));
    cfg_write(2'd3, 15'($urandom_range(0, 32767)));
    check("trk_frozen", trk_now(), m_trk);

    // three frames in rotation, then slot2 misses four visits and recovers
    tracked_frame(1'b1, 0, 1'b0);
    tracked_frame(1'($urandom_range(0, 1)), 0, 1'b0);
    tracked_frame(1'b0, 0, 1'b0);
    for (int v = 0, s2 = 1; v < 12; v++) begin
      if (m_slot == 2) begin
        s2++;
        tracked_frame(s2 > 4, 0, 1'b0);
      end else begin
        tracked_frame(1'($urandom_range(0, 1)), 0, 1'b0);
      end
    end
    cfg_write(2'd2, 15'($urandom_range(0, 32767)));

    // stalled results: two skipped frames, then a release coinciding with frame end
    tracked_frame(1'b1, 2, 1'b0);
    tracked_frame(1'b0, 1, 1'b1);

    // sched_en dropped in TRACK: deliver, park, ignore frames, resume
    @(negedge clk);
    sched_en = 1'b0;
    tracked_frame(1'b1, 0, 1'b0);
    vsync_fall(3);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("idle_no_valid", res_valid, 1'b0);
    end
    @(negedge clk);
    sched_en = 1'b1;
    vsync_fall(2);
    settle();
    settle();
    m_trk = m_prof[m_slot];
    check("resume_trk", trk_now(), m_trk);
    check("resume_slot", active_slot, m_slot);

    // reset in TRACK abandons the frame
    cfg_write(2'd0, 15'($urandom_range(0, 32767)));
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_slot", active_slot, 2'd0);
    check("mid_rst_trk", trk_now(), RST_PROF);
    check("mid_rst_lost", lost, 3'd0);
    check("mid_rst_res", {res_slot, res_hit, res_x, res_y, frame_skip}, 24'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    settle();
    check("post_rst_arm", res_valid, 1'b0);
    settle();
    check("post_rst_track", res_valid, 1'b0);
    check("post_rst_trk", trk_now(), RST_PROF);
    tracked_frame(1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
